hilo_muldiv_ctrl: RTL and testbench
===================================

Name: hilo_muldiv_ctrl

Overview:
Multi-cycle sequencer for the ALU's MULT/MULTU/DIV/DIVU operations and owner of the architectural HI/LO registers.
- Accepts a mul/div issue from the decode stage and latches its operands.
- Drives the shared ALU for a fixed per-class latency, then captures result→LO and hi→HI.
- Stalls MFHI/MFLO/MTHI/MTLO and any new issue while an operation is in flight.
- Sits between the ID/EX pipeline control and the ALU mul/div path.

Parameters:
data_width, 32, operand/HI/LO width
MULT_CYCLES, 4, busy cycles for MULT/MULTU (≥1)
DIV_CYCLES, 32, busy cycles for DIV/DIVU (≥1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  issue request, sampled each edge
op  in  5  ALU opcode of the issue: MULT=11, MULTU=12, DIV=13, DIVU=14
rs_val  in  data_width  operand 1 (dividend / multiplicand)
rt_val  in  data_width  operand 2 (divisor / multiplier)
mfhi  in  1  read-HI request
mflo  in  1  read-LO request
mthi  in  1  write-HI request
mtlo  in  1  write-LO request
wr_data  in  data_width  MTHI/MTLO data
rd_data  out  data_width  MFHI/MFLO data
stall  out  1  pipeline hold
busy  out  1  operation in flight
illegal_op  out  1  one-cycle pulse: start with an op outside 11..14
div_zero  out  1  one-cycle pulse: DIV/DIVU completed with divisor 0
alu_opcode  out  5  opcode driven to the ALU
alu_s1  out  data_width  ALU in_s1
alu_s2  out  data_width  ALU in_s2
alu_result  in  data_width  ALU result (low word / quotient)
alu_hi  in  data_width  ALU hi (high word / remainder)
hi  out  data_width  HI register
lo  out  data_width  LO register

Behaviour:
- Reset values: hi=0, lo=0, busy=0, stall=0, illegal_op=0, div_zero=0, alu_opcode=0 (ADD), alu_s1=0, alu_s2=0, state=IDLE, counter=0.
- Reset is valid mid-operation: the in-flight op is discarded and HI/LO are cleared.
- FSM has two states, IDLE and BUSY.
- IDLE, start=1, op in 11..14:
  - latch op, rs_val, rt_val into alu_opcode/alu_s1/alu_s2;
  - load counter = (MULT_CYCLES or DIV_CYCLES) − 1;
  - go to BUSY.
- IDLE, start=1, op illegal: illegal_op=1 next cycle; state, HI and LO unchanged.
- BUSY:
  - ALU outputs held stable;
  - counter decrements each cycle;
  - at counter==0: lo←alu_result, hi←alu_hi, return to IDLE.
- Latency: busy is high exactly N cycles (N = MULT_CYCLES or DIV_CYCLES), starting the cycle after the accepting edge. The new HI/LO are visible on the edge that clears busy.
- Divide by zero (DIV/DIVU with latched rt=0): at completion HI/LO are left unchanged and div_zero pulses for one cycle.
- In IDLE, alu_opcode/alu_s1/alu_s2 hold their last values; the ALU is free to be used by other paths.
- stall = busy & (start | mfhi | mflo | mthi | mtlo), combinational. A stalled request has no effect and must be held by the pipeline.
- MFHI/MFLO when not stalled: rd_data = hi (mfhi) or lo (mflo), combinational; rd_data=0 when no read is requested. If mfhi and mflo are both high, HI wins.
- MTHI/MTLO when not stalled: the targeted register is written at the edge; both may be written in the same cycle.
- Same-cycle start and MTHI/MTLO in IDLE: the write takes effect and the op is accepted. The op's later result overwrites HI/LO (program-order semantics).
- Same-cycle start and MFHI/MFLO in IDLE: the read returns the pre-op value.
- Completion edge: busy has fallen, so a request arriving on the next cycle is unstalled and sees the new HI/LO. A back-to-back start is accepted the cycle after busy drops.

Test Plan:
- MULT rs=-3 (0xFFFFFFFD), rt=1, MULT_CYCLES=4 → busy high exactly 4 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF; mflo returns 0xFFFFFFFD.
- MULTU rs=0xFFFFFFFD, rt=0xFFFFFFFF → lo=0x00000003, hi=0xFFFFFFFC.
- DIV rs=-8, rt=3 → after 32 busy cycles lo=0xFFFFFFFE, hi=0xFFFFFFFE; DIVU rs=8, rt=3 → lo=2, hi=2.
- mfhi asserted 2 cycles after a DIV start → stall=1 until busy falls, then rd_data equals the new HI. An mthi 0x1234 issued during busy is stalled and applied only after completion, giving hi=0x1234.
- DIV with rt=0 and preset hi=0xAAAA, lo=0x5555 → div_zero pulses once; hi and lo unchanged. start with op=5 → illegal_op pulse, busy stays 0.
- rst asserted mid-DIV (cycle 10) → next cycle busy=0, hi=0, lo=0, stall=0; a fresh MULT issued afterwards completes normally.

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - HI/LO owner and multi-cycle MULT/DIV sequencer
//
// Ports:
//   clk, rst               rising-edge clock, synchronous active-high reset
//   start, op              mul/div issue from decode (op: 11..14)
//   rs_val, rt_val         issue operands
//   mfhi, mflo, rd_data    HI/LO reads (combinational)
//   mthi, mtlo, wr_data    HI/LO writes
//   stall, busy            pipeline hold / operation in flight
//   illegal_op, div_zero   one-cycle status pulses
//   alu_opcode/s1/s2       drive to the shared ALU
//   alu_result, alu_hi     ALU low word/quotient and high word/remainder
//   hi, lo                 architectural HI/LO registers
module hilo_muldiv_ctrl #(
    parameter int data_width  = 32,
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4:0]            op,
    input  logic [data_width-1:0] rs_val,
    input  logic [data_width-1:0] rt_val,
    input  logic                  mfhi,
    input  logic                  mflo,
    input  logic                  mthi,
    input  logic                  mtlo,
    input  logic [data_width-1:0] wr_data,
    output logic [data_width-1:0] rd_data,
    output logic                  stall,
    output logic                  busy,
    output logic                  illegal_op,
    output logic                  div_zero,
    output logic [4:0]            alu_opcode,
    output logic [data_width-1:0] alu_s1,
    output logic [data_width-1:0] alu_s2,
    input  logic [data_width-1:0] alu_result,
    input  logic [data_width-1:0] alu_hi,
    output logic [data_width-1:0] hi,
    output logic [data_width-1:0] lo
);

    localparam logic [4:0] OP_MULT  = 5'd11;
    localparam logic [4:0] OP_DIV   = 5'd13;
    localparam logic [4:0] OP_DIVU  = 5'd14;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] counter;
    logic             op_legal;
    logic             op_is_div;
    logic             accept;
    logic             done;
    logic             latched_div_zero;
    logic             any_req;

    always_comb begin
        state_next       = state;
        op_legal         = (op >= OP_MULT) && (op <= OP_DIVU);
        op_is_div        = (op == OP_DIV) || (op == OP_DIVU);
        accept           = 1'b0;
        done             = 1'b0;
        // The divide-by-zero decision uses the latched operands, not the live inputs.
        latched_div_zero = ((alu_opcode == OP_DIV) || (alu_opcode == OP_DIVU)) &&
                           (alu_s2 == '0);
        any_req          = start | mfhi | mflo | mthi | mtlo;
        busy             = 1'b0;
        stall            = 1'b0;
        rd_data          = '0;

        case (state)
            IDLE: begin
                if (start && op_legal) begin
                    accept     = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (counter == '0) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        stall = busy & any_req;

        // A stalled read returns nothing; the pipeline re-presents it later.
        if (!stall) begin
            if (mfhi) begin
                rd_data = hi;
            end else if (mflo) begin
                rd_data = lo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            counter    <= '0;
            hi         <= '0;
            lo         <= '0;
            alu_opcode <= 5'd0;
            alu_s1     <= '0;
            alu_s2     <= '0;
            illegal_op <= 1'b0;
            div_zero   <= 1'b0;
        end else begin
            state      <= state_next;
            illegal_op <= (state == IDLE) && start && !op_legal;
            div_zero   <= done && latched_div_zero;

            case (state)
                IDLE: begin
                    // Register writes land even when an op is accepted on the same
                    // edge; the op's result overwrites them later (program order).
                    if (mthi) begin
                        hi <= wr_data;
                    end
                    if (mtlo) begin
                        lo <= wr_data;
                    end
                    if (accept) begin
                        alu_opcode <= op;
                        alu_s1     <= rs_val;
                        alu_s2     <= rt_val;
                        counter    <= op_is_div ? DIV_LOAD : MULT_LOAD;
                    end
                end
                BUSY: begin
                    if (done) begin
                        counter <= '0;
                        if (!latched_div_zero) begin
                            hi <= alu_hi;
                            lo <= alu_result;
                        end
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end
                default: counter <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb/tb_hilo_muldiv_ctrl.sv - self-checking bench for hilo_muldiv_ctrl
module tb_hilo_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  op;
    logic [31:0] rs_val, rt_val, wr_data;
    logic        mfhi, mflo, mthi, mtlo;
    logic [31:0] rd_data;
    logic        stall, busy, illegal_op, div_zero;
    logic [4:0]  alu_opcode;
    logic [31:0] alu_s1, alu_s2, alu_result, alu_hi, hi, lo;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hilo_muldiv_ctrl #(
        .data_width (32),
        .MULT_CYCLES(4),
        .DIV_CYCLES (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .mfhi      (mfhi),
        .mflo      (mflo),
        .mthi      (mthi),
        .mtlo      (mtlo),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .stall     (stall),
        .busy      (busy),
        .illegal_op(illegal_op),
        .div_zero  (div_zero),
        .alu_opcode(alu_opcode),
        .alu_s1    (alu_s1),
        .alu_s2    (alu_s2),
        .alu_result(alu_result),
        .alu_hi    (alu_hi),
        .hi        (hi),
        .lo        (lo)
    );

    // Behavioural stand-in for the shared ALU mul/div path.
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    always_comb begin
        alu_result = 32'h0;
        alu_hi     = 32'h0;
        prod_s     = $signed({{32{alu_s1[31]}}, alu_s1}) * $signed({{32{alu_s2[31]}}, alu_s2});
        prod_u     = {32'h0, alu_s1} * {32'h0, alu_s2};
        case (alu_opcode)
            5'd11: {alu_hi, alu_result} = prod_s;
            5'd12: {alu_hi, alu_result} = prod_u;
            5'd13: begin
                if (alu_s2 == 32'h0) begin
                    alu_result = 32'hDEADBEEF;
                    alu_hi     = 32'hDEADBEEF;
                end else begin
                    alu_result = $signed(alu_s1) / $signed(alu_s2);
                    alu_hi     = $signed(alu_s1) % $signed(alu_s2);
                end
            end
            5'd14: begin
                if (alu_s2 == 32'h0) begin
                    alu_result = 32'hDEADBEEF;
                    alu_hi     = 32'hDEADBEEF;
                end else begin
                    alu_result = alu_s1 / alu_s2;
                    alu_hi     = alu_s1 % alu_s2;
                end
            end
            default: ;
        endcase
    end

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          cyc;
        bit          dz;
        bit          ill;
    } exp_t;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        bit          preset;
        logic [31:0] p_hi;
        logic [31:0] p_lo;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
        mthi = 1'b1; wr_data = h; step(); mthi = 1'b0;
        mtlo = 1'b1; wr_data = l; step(); mtlo = 1'b0;
    endtask

    task automatic issue(input string nm, input logic [4:0] o, input logic [31:0] a,
                         input logic [31:0] b, input exp_t e);
        exp_t got;
        int   cycles;
        sb.push_back(e);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        step();
        start = 1'b0;
        got = sb.pop_front();
        if (got.ill) begin
            chk({nm, " illegal_op"}, {31'h0, illegal_op}, 32'h1);
            chk({nm, " busy"}, {31'h0, busy}, 32'h0);
            step();
            chk({nm, " illegal_op clr"}, {31'h0, illegal_op}, 32'h0);
        end else begin
            cycles = 0;
            while (busy && cycles < 200) begin
                cycles++;
                step();
            end
            chk({nm, " busy cycles"}, cycles, got.cyc);
            chk({nm, " div_zero"}, {31'h0, div_zero}, {31'h0, got.dz});
            step();
            chk({nm, " div_zero clr"}, {31'h0, div_zero}, 32'h0);
        end
        chk({nm, " lo"}, lo, got.lo);
        chk({nm, " hi"}, hi, got.hi);
    endtask

    initial begin
        int   cycles;
        bit   stall_ok;
        exp_t e;

        vecs[0] = '{"mult_neg",   5'd11, 32'hFFFFFFFD, 32'h1, 1'b0, 0, 0,
                    '{32'hFFFFFFFD, 32'hFFFFFFFF, 4, 1'b0, 1'b0}};
        vecs[1] = '{"multu_big",  5'd12, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 0, 0,
                    '{32'h00000003, 32'hFFFFFFFC, 4, 1'b0, 1'b0}};
        vecs[2] = '{"div_neg",    5'd13, 32'hFFFFFFF8, 32'h3, 1'b0, 0, 0,
                    '{32'hFFFFFFFE, 32'hFFFFFFFE, 32, 1'b0, 1'b0}};
        vecs[3] = '{"divu_8_3",   5'd14, 32'h8, 32'h3, 1'b0, 0, 0,
                    '{32'h2, 32'h2, 32, 1'b0, 1'b0}};
        vecs[4] = '{"div_zero",   5'd13, 32'h1234, 32'h0, 1'b1, 32'hAAAA, 32'h5555,
                    '{32'h5555, 32'hAAAA, 32, 1'b1, 1'b0}};
        vecs[5] = '{"illegal_5",  5'd5, 32'h1, 32'h2, 1'b1, 32'h1111, 32'h2222,
                    '{32'h2222, 32'h1111, 0, 1'b0, 1'b1}};
        vecs[6] = '{"mult_7_m6",  5'd11, 32'h7, 32'hFFFFFFFA, 1'b0, 0, 0,
                    '{32'hFFFFFFD6, 32'hFFFFFFFF, 4, 1'b0, 1'b0}};
        vecs[7] = '{"divu_max",   5'd14, 32'hFFFFFFFF, 32'h10, 1'b0, 0, 0,
                    '{32'h0FFFFFFF, 32'h0000000F, 32, 1'b0, 1'b0}};

        rst = 1'b1; start = 1'b0; op = 5'd0; rs_val = 0; rt_val = 0;
        mfhi = 1'b0; mflo = 1'b0; mthi = 1'b0; mtlo = 1'b0; wr_data = 0;
        step(); step();
        chk("rst hi", hi, 32'h0);
        chk("rst lo", lo, 32'h0);
        chk("rst busy", {31'h0, busy}, 32'h0);
        chk("rst illegal", {31'h0, illegal_op}, 32'h0);
        chk("rst div_zero", {31'h0, div_zero}, 32'h0);
        chk("rst alu_opcode", {27'h0, alu_opcode}, 32'h0);
        chk("rst alu_s1", alu_s1, 32'h0);
        chk("rst alu_s2", alu_s2, 32'h0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].preset) write_hilo(vecs[i].p_hi, vecs[i].p_lo);
            issue(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].e);
            mflo = 1'b1; #1;
            chk({vecs[i].name, " mflo"}, rd_data, vecs[i].e.lo);
            mfhi = 1'b1; #1;
            chk({vecs[i].name, " mfhi wins"}, rd_data, vecs[i].e.hi);
            mfhi = 1'b0; mflo = 1'b0; #1;
            chk({vecs[i].name, " no read"}, rd_data, 32'h0);
        end

        // mfhi raised mid-DIV: stalled until busy falls, then sees the new HI.
        start = 1'b1; op = 5'd13; rs_val = 32'hFFFFFFF8; rt_val = 32'h3;
        step(); start = 1'b0;
        step(); step();
        mfhi = 1'b1; #1;
        stall_ok = 1'b1; cycles = 0;
        while (busy && cycles < 200) begin
            if (!stall) stall_ok = 1'b0;
            cycles++;
            step();
        end
        chk("mfhi stalled while busy", {31'h0, stall_ok}, 32'h1);
        chk("mfhi stall released", {31'h0, stall}, 32'h0);
        chk("mfhi new hi", rd_data, 32'hFFFFFFFE);
        mfhi = 1'b0;

        // mthi raised mid-DIVU: applied only after completion.
        start = 1'b1; op = 5'd14; rs_val = 32'h8; rt_val = 32'h3;
        step(); start = 1'b0;
        step();
        mthi = 1'b1; wr_data = 32'h1234; #1;
        chk("mthi stall", {31'h0, stall}, 32'h1);
        cycles = 0;
        while (busy && cycles < 200) begin
            cycles++;
            step();
        end
        chk("mthi held hi=result", hi, 32'h2);
        step(); mthi = 1'b0;
        chk("mthi applied", hi, 32'h1234);
        chk("mthi lo", lo, 32'h2);

        // Same-cycle start + mtlo + mflo in IDLE.
        start = 1'b1; op = 5'd12; rs_val = 32'h2; rt_val = 32'h3;
        mtlo = 1'b1; mflo = 1'b1; wr_data = 32'h77; #1;
        chk("start+mflo pre-op value", rd_data, 32'h2);
        chk("start+mflo no stall", {31'h0, stall}, 32'h0);
        step(); start = 1'b0; mtlo = 1'b0; mflo = 1'b0;
        chk("start+mtlo write landed", lo, 32'h77);
        chk("start+mtlo accepted", {31'h0, busy}, 32'h1);
        cycles = 0;
        while (busy && cycles < 200) begin
            cycles++;
            step();
        end
        chk("start+mtlo result lo", lo, 32'h6);
        chk("start+mtlo result hi", hi, 32'h0);

        // Reset in the middle of a DIV.
        start = 1'b1; op = 5'd13; rs_val = 32'h100; rt_val = 32'h7;
        step(); start = 1'b0;
        for (int k = 0; k < 9; k++) step();
        rst = 1'b1;
        step();
        rst = 1'b0; mfhi = 1'b1; #1;
        chk("midrst busy", {31'h0, busy}, 32'h0);
        chk("midrst hi", hi, 32'h0);
        chk("midrst lo", lo, 32'h0);
        chk("midrst stall", {31'h0, stall}, 32'h0);
        mfhi = 1'b0;
        e = '{32'd15, 32'd0, 4, 1'b0, 1'b0};
        issue("post_rst_mult", 5'd11, 32'd5, 32'd3, e);
        // Back-to-back: issued on the cycle after busy fell.
        e = '{32'hFFFFFFF1, 32'hFFFFFFFF, 4, 1'b0, 1'b0};
        issue("b2b_mult", 5'd11, 32'd5, 32'hFFFFFFFD, e);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
